// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the Execute stage: DIV/DIVU/REM/REMU,
// 32 iterations per normal op, single-cycle bypass for divide-by-zero and signed overflow.
module div_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_E,
   input  logic [1:0]            div_op,
   input  logic [DATA_WIDTH-1:0] RD1,
   input  logic [DATA_WIDTH-1:0] RD2,
   input  logic                  flush_E,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done,
   output logic                  busy,
   output logic                  stall_E
);
   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        r_state;
   logic [5:0]    r_cnt;
   logic          r_rem_op;
   logic          r_neg_q;
   logic          r_neg_r;
   logic [W-1:0]  r_div;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_result;

   logic          w_signed, w_neg_a, w_neg_b, w_start, w_div0, w_ovf, w_ge;
   logic [W-1:0]  w_abs_a, w_abs_b, w_spec_res, w_rem_nx, w_quo_nx, w_final;
   logic [W:0]    w_sh, w_diff;

   assign w_signed = ~div_op[0];
   assign w_neg_a  = w_signed & RD1[W-1];
   assign w_neg_b  = w_signed & RD2[W-1];
   assign w_abs_a  = w_neg_a ? -RD1 : RD1;
   assign w_abs_b  = w_neg_b ? -RD2 : RD2;
   assign w_start  = start_E & ~flush_E;
   assign w_div0   = (RD2 == '0);
   assign w_ovf    = w_signed && (RD1 == MIN_NEG) && (RD2 == '1);
   assign w_spec_res = w_div0 ? (div_op[1] ? RD1 : '1) : (div_op[1] ? '0 : MIN_NEG);

   // Partial remainder is always < divisor, so the borrow out of w_diff decides the quotient bit.
   assign w_sh     = {r_rem, r_quo[W-1]};
   assign w_diff   = w_sh - {1'b0, r_div};
   assign w_ge     = ~w_diff[W];
   assign w_rem_nx = w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
   assign w_quo_nx = {r_quo[W-2:0], w_ge};
   assign w_final  = r_rem_op ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                              : (r_neg_q ? -w_quo_nx : w_quo_nx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem_op <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_start) begin
               r_rem_op <= div_op[1];
               r_neg_q  <= w_neg_a ^ w_neg_b;
               r_neg_r  <= w_neg_a;
               r_div    <= w_abs_b;
               r_quo    <= w_abs_a;
               r_rem    <= '0;
               r_cnt    <= '0;
               if (w_div0 || w_ovf) begin
                  r_result <= w_spec_res;
                  r_state  <= DONE;
               end else begin
                  r_state  <= CALC;
               end
            end
            CALC: if (flush_E) begin
               r_state <= IDLE;
            end else begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_result <= w_final;
                  r_state  <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign result  = r_result;
   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE) && !flush_E;
   // Gated by rst_n so a held start_E cannot stall the pipe during reset.
   assign stall_E = rst_n && (((r_state == IDLE) && w_start) || (r_state == CALC));
endmodule

// File: tb/tb_div_sequencer.sv
// Directed + random checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, start_E = 1'b0, flush_E = 1'b0;
   logic [1:0]  div_op = 2'd0;
   logic [31:0] RD1 = '0, RD2 = '0;
   logic [31:0] result;
   logic        done, busy, stall_E;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   div_sequencer #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_E(start_E), .div_op(div_op),
      .RD1(RD1), .RD2(RD2), .flush_E(flush_E),
      .result(result), .done(done), .busy(busy), .stall_E(stall_E)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      case (op)
         2'd0:    return 32'($signed(a) / $signed(b));
         2'd1:    return a / b;
         2'd2:    return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // Called just after a rising edge; that cycle is N.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int   lat = 0;
      logic stall_ok = 1'b1;
      div_op = op; RD1 = a; RD2 = b; start_E = 1'b1; #1;
      chk({tag, "/stallN"}, 32'(stall_E), 32'd1);
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(posedge clk); #1;
         RD1 = $urandom; RD2 = $urandom; div_op = 2'($urandom);
         if (done) begin
            lat = c;
            chk({tag, "/result"}, result, exp);
            chk({tag, "/stallDone"}, 32'(stall_E), 32'd0);
            start_E = 1'b0;
         end else if (stall_E !== 1'b1 || busy !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
      chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/stallBusy"}, 32'(stall_ok), 32'd1);
      @(posedge clk); #1;
      chk({tag, "/idleAfter"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "/hold"}, result, exp);
   endtask

   initial begin
      logic [31:0] prev, a, b;
      logic [1:0]  op;
      logic        no_done;
      start_E = 1'b1;
      #3;
      chk("reset/outs", {29'd0, done, busy, stall_E}, 32'd0);
      chk("reset/result", result, 32'd0);
      #9; rst_n = 1'b1; start_E = 1'b0;
      @(posedge clk); #1;

      do_op("divu100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33);
      do_op("div-20_3",  2'd0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
      do_op("rem-20_3",  2'd2, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
      do_op("remu",      2'd3, 32'hFFFF_FFEC, 32'd3, 32'h0000_0002, 33);
      do_op("divu5_0",   2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu5_0",   2'd3, 32'd5, 32'd0, 32'd5, 1);
      do_op("div_ovf",   2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

      // Flush mid-calculation.
      prev = result;
      div_op = 2'd1; RD1 = 32'd1000; RD2 = 32'd7; start_E = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      flush_E = 1'b1; start_E = 1'b0; #1;
      chk("flush/noDoneN10", 32'(done), 32'd0);
      @(posedge clk); #1;
      flush_E = 1'b0;
      chk("flush/idle", {30'd0, busy, stall_E}, 32'd0);
      chk("flush/result", result, prev);
      no_done = 1'b1;
      repeat (40) begin @(posedge clk); #1; if (done !== 1'b0) no_done = 1'b0; end
      chk("flush/noDone", 32'(no_done), 32'd1);
      do_op("divu9_3", 2'd1, 32'd9, 32'd3, 32'd3, 33);

      // Asynchronous reset mid-calculation.
      div_op = 2'd1; RD1 = 32'd100; RD2 = 32'd7; start_E = 1'b1;
      repeat (15) begin @(posedge clk); #1; end
      #2; rst_n = 1'b0; #1;
      chk("rst/outs", {29'd0, done, busy, stall_E}, 32'd0);
      chk("rst/result", result, 32'd0);
      @(posedge clk); #3;
      start_E = 1'b0; rst_n = 1'b1;
      no_done = 1'b1;
      repeat (40) begin @(posedge clk); #1; if (done !== 1'b0) no_done = 1'b0; end
      chk("rst/noDone", 32'(no_done), 32'd1);
      do_op("postRst", 2'd1, 32'd100, 32'd7, 32'd14, 33);

      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3:       b = -32'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         do_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b), is_special(op, a, b) ? 1 : 33);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
